oclib_uart_rx: RTL and testbench
================================

// Module: oclib_uart_rx
// PURPOSE
// - Synthesizable UART receiver: turns the async serial line from the sim UART model (or a board pin) into bytes.
// - Output is a valid/ready byte stream feeding the command/CSR parser, buffered by a small FIFO.
// - Frame: 1 start bit, 8 data bits LSB first, optional parity bit, 1 stop bit.
// PARAMETERS
// - ClockHz    100000000  clock frequency in Hz
// - Baud       115200     line rate; CyclesPerBit = (ClockHz + Baud/2) / Baud, must be >= 8
// - SyncCycles 3          rx synchronizer flops, >= 2
// - FifoDepth  4          output FIFO entries, power of 2, >= 2
// PORTS
// - clock          in   1  clock
// - resetn         in   1  synchronous active-low reset
// - rx             in   1  async serial input, idles high
// - rxData         out  8  byte at FIFO head
// - rxValid        out  1  FIFO non-empty
// - rxReady        in   1  consumer accepts rxData when rxValid && rxReady
// - busy           out  1  FSM not in IDLE
// - framingError   out  1  one-cycle pulse, stop bit sampled low
// - overflowError  out  1  one-cycle pulse, completed byte dropped because FIFO full
// - parityError    out  1  one-cycle pulse, parity mismatch (see CONFIGURATION)
// BEHAVIOUR
// - Reset (resetn==0 at clock edge): synchronizer flops = 1, FSM = IDLE, counters = 0, FIFO empty.
//   rxValid/busy/error pulses = 0; rxData = 0. Reset mid-frame discards the partial byte.
// - rx passes through SyncCycles flops; all decisions use the synced value rxS.
// - Bit timer counts 0..CyclesPerBit-1; a "sample" is taken when the timer reaches its terminal count.
// - FSM:
//   IDLE:   rxS falling (1->0) -> START, timer preloaded so first sample is at CyclesPerBit/2.
//   START:  sample rxS: 0 -> DATA (bitIdx=0); 1 -> IDLE (glitch, no error flagged).
//   DATA:   each sample shifts rxS into shift[bitIdx], LSB first; after bitIdx==7 -> PARITY if enabled, else STOP.
//   PARITY: sample compared with even parity of the 8 data bits -> STOP.
//   STOP:   sample 1 -> push byte (unless parity failed) -> IDLE.
//           sample 0 -> framingError pulse, byte dropped -> BREAK.
//   BREAK:  wait until rxS==1, then IDLE (a held-low line yields exactly one framingError).
// - Latency: byte visible on rxData with rxValid=1 on the 1st cycle after the stop-bit sample edge.
// - FIFO: write on good stop bit; read on rxValid && rxReady; rxData = head entry (registered-output FIFO not required).
//   Full + push with no pop -> byte dropped, overflowError pulse, FIFO unchanged.
//   Full + push + pop same cycle -> both succeed, no overflow.
//   Empty: rxValid=0, rxReady ignored; rxData holds last value.
//   Pointers wrap modulo FifoDepth; count is log2(FifoDepth)+1 bits.
// - Error pulses are mutually exclusive per frame and last exactly one cycle.
// CONFIGURATION
// - OCLIB_UART_RX_PARITY_EN defined: PARITY state present; frame has a 9th even-parity bit before stop;
//   mismatch -> parityError pulse at stop-bit sample time, byte dropped (not pushed), no overflow counted.
// - Not defined: PARITY state absent, DATA goes directly to STOP, parityError tied 0.
// TESTING (ClockHz=100MHz, Baud=115200 -> 868 cycles/bit, FifoDepth=4, rxReady=1 unless stated)
// - Send 0x55, then 0xA3 back to back -> rxData 0x55 then 0xA3 each with a 1-cycle rxValid; no errors.
// - 2000ns low glitch on idle rx -> FSM returns to IDLE, no byte, no error pulses, busy drops.
// - Frame 0x41 with stop bit driven 0, then rx held low 20 bit-times -> exactly one framingError, FIFO empty.
// - rxReady=0, send 5 bytes 0x01..0x05 -> 4 stored, one overflowError on byte 5;
//   raise rxReady -> 0x01..0x04 drain in order.
// - Assert resetn=0 for 1 cycle at data bit 3 of 0x7E -> no byte, no error; next clean 0x7E is received correctly.
// - With OCLIB_UART_RX_PARITY_EN: 0x07 with parity 1 -> received;
//   with parity 0 -> parityError pulse, no rxValid.

Source files
------------

// File: rtl/oclib_uart_rx_if.sv
// oclib_uart_rx_if: valid/ready byte stream from the UART receiver to its consumer.
// master = receiver side (drives data/valid), slave = consumer side (drives ready).
interface oclib_uart_rx_if;
  logic [7:0] rxData;
  logic       rxValid;
  logic       rxReady;

  modport master (output rxData, output rxValid, input rxReady);
  modport slave  (input rxData, input rxValid, output rxReady);
endinterface

// File: rtl/oclib_uart_rx.sv
// oclib_uart_rx: UART receiver (8N1, optional even parity) with a small output FIFO.
// Optional feature macro: OCLIB_UART_RX_PARITY_EN adds a 9th even-parity bit before stop.
module oclib_uart_rx #(
  parameter int unsigned ClockHz    = 100000000,
  parameter int unsigned Baud       = 115200,
  parameter int unsigned SyncCycles = 3,
  parameter int unsigned FifoDepth  = 4
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            rx,
  oclib_uart_rx_if.master out_if,
  output logic            busy,
  output logic            framingError,
  output logic            overflowError,
  output logic            parityError
);
  localparam int unsigned CyclesPerBit = (ClockHz + Baud / 2) / Baud;
  localparam int unsigned TimerW       = $clog2(CyclesPerBit);
  localparam int unsigned FifoAw       = $clog2(FifoDepth);
  localparam int unsigned CountW       = FifoAw + 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(CyclesPerBit - 1);
  // Preload so the first sample lands half a bit after the falling edge.
  localparam logic [TimerW-1:0] TimerHalf = TimerW'(CyclesPerBit - 1 - CyclesPerBit / 2);

  typedef enum logic [2:0] {
    StIdle, StStart, StData, StStop, StBreak
`ifdef OCLIB_UART_RX_PARITY_EN
    , StParity
`endif
  } state_e;

  logic [SyncCycles-1:0] sync_q;
  logic                  rxs, rxs_prev_q;
  state_e                state_q, state_d;
  logic [TimerW-1:0]     timer_q, timer_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [7:0]            shift_q, shift_d;
  logic                  tick, push, framing_d, framing_q, overflow_d, overflow_q;
`ifdef OCLIB_UART_RX_PARITY_EN
  logic                  par_bad_q, par_bad_d, parity_err_q, parity_err_d;
`endif

  assign rxs  = sync_q[SyncCycles-1];
  assign tick = (timer_q == TimerLast);
  assign busy = (state_q != StIdle);

  // Input synchronizer plus one-cycle history for falling-edge detection.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync_q     <= '1;
      rxs_prev_q <= 1'b1;
    end else begin
      sync_q     <= {sync_q[SyncCycles-2:0], rx};
      rxs_prev_q <= rxs;
    end
  end

  // Receive FSM next-state, bit timer and shift register.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    framing_d = 1'b0;
`ifdef OCLIB_UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    if (state_q != StIdle && state_q != StBreak) begin
      timer_d = tick ? '0 : timer_q + 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        if (rxs_prev_q && !rxs) begin
          state_d = StStart;
          timer_d = TimerHalf;
`ifdef OCLIB_UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      StStart: begin
        if (tick) begin
          // A start bit that is high again at mid-bit was a glitch.
          if (!rxs) begin
            state_d   = StData;
            bit_idx_d = 3'd0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StData: begin
        if (tick) begin
          shift_d[bit_idx_q] = rxs;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef OCLIB_UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef OCLIB_UART_RX_PARITY_EN
      StParity: begin
        if (tick) begin
          par_bad_d = (rxs != ^shift_q);
          state_d   = StStop;
        end
      end
`endif
      StStop: begin
        if (tick) begin
          if (rxs) begin
`ifdef OCLIB_UART_RX_PARITY_EN
            if (par_bad_q) parity_err_d = 1'b1;
            else
`endif
            push = 1'b1;
            state_d = StIdle;
          end else begin
            framing_d = 1'b1;
            state_d   = StBreak;
          end
        end
      end
      StBreak: begin
        // Hold here while the line stays low so a break yields one framing error.
        if (rxs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state and error-pulse registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      framing_q  <= 1'b0;
      overflow_q <= 1'b0;
`ifdef OCLIB_UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      framing_q  <= framing_d;
      overflow_q <= overflow_d;
`ifdef OCLIB_UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign framingError  = framing_q;
  assign overflowError = overflow_q;
`ifdef OCLIB_UART_RX_PARITY_EN
  assign parityError = parity_err_q;
`else
  assign parityError = 1'b0;
`endif

  // Output FIFO.
  logic [7:0]        mem_q [FifoDepth];
  logic [FifoAw-1:0] wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0] count_q;
  logic [7:0]        last_q;
  logic              empty, full, pop, wr_en;

  assign empty      = (count_q == '0);
  assign full       = (count_q == CountW'(FifoDepth));
  assign pop        = !empty && out_if.rxReady;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign wr_en      = push && (!full || pop);
  assign overflow_d = push && full && !pop;

  assign out_if.rxValid = !empty;
  assign out_if.rxData  = empty ? last_q : mem_q[rd_ptr_q];

  // FIFO storage; no reset needed since entries are only read when valid.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= shift_q;
  end

  // FIFO pointers, occupancy and last-popped byte.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        last_q   <= mem_q[rd_ptr_q];
      end
      if (wr_en && !pop) count_q <= count_q + 1'b1;
      else if (!wr_en && pop) count_q <= count_q - 1'b1;
    end
  end
endmodule

// File: tb/tb_oclib_uart_rx.sv
// tb_oclib_uart_rx: randomized and directed frames checked against a byte-queue model.
// Uses a fast line rate (16 clocks per bit) so the run stays short.
`timescale 1ns/1ps
module tb_oclib_uart_rx;
  localparam int unsigned ClockHz = 16000000;
  localparam int unsigned Baud    = 1000000;
  localparam int unsigned Cpb     = (ClockHz + Baud / 2) / Baud;
  localparam int unsigned Depth   = 4;
`ifdef OCLIB_UART_RX_PARITY_EN
  localparam bit ParityEn = 1'b1;
`else
  localparam bit ParityEn = 1'b0;
`endif

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic rx = 1'b1;
  logic busy, framingError, overflowError, parityError;

  oclib_uart_rx_if rx_if ();

  oclib_uart_rx #(
    .ClockHz   (ClockHz),
    .Baud      (Baud),
    .SyncCycles(3),
    .FifoDepth (Depth)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .rx           (rx),
    .out_if       (rx_if),
    .busy         (busy),
    .framingError (framingError),
    .overflowError(overflowError),
    .parityError  (parityError)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  int fe_exp = 0, ov_exp = 0, pe_exp = 0;
  int fe_seen = 0, ov_seen = 0, pe_seen = 0, valid_hi = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: observed %0h, required %0h", tag, got, exp);
    end
  endtask

  // Consumer side: every accepted byte must be the oldest one the model expects.
  always @(negedge clock) begin
    if (resetn) begin
      if (framingError) fe_seen++;
      if (overflowError) ov_seen++;
      if (parityError) pe_seen++;
      if (rx_if.rxValid) valid_hi++;
      if (rx_if.rxValid && rx_if.rxReady) begin
        if (exp_q.size() == 0) check("spurious_byte_valid", {31'd0, rx_if.rxValid}, 32'd0);
        else check("rx_data", {24'd0, rx_if.rxData}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (Cpb) @(negedge clock);
  endtask

  task automatic idle(input int cycles);
    rx = 1'b1;
    repeat (cycles) @(negedge clock);
  endtask

  // Model decides the frame's fate up front, then the line is driven.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_flip);
    if (!stop_bit) fe_exp++;
    else if (ParityEn && par_flip) pe_exp++;
    else if (exp_q.size() >= Depth) ov_exp++;
    else exp_q.push_back(data);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    if (ParityEn) drive_bit((^data) ^ par_flip);
    drive_bit(stop_bit);
  endtask

  task automatic check_counts(input string where);
    check({where, "_framing_pulses"}, fe_seen, fe_exp);
    check({where, "_overflow_pulses"}, ov_seen, ov_exp);
    check({where, "_parity_pulses"}, pe_seen, pe_exp);
    check({where, "_pending_bytes"}, exp_q.size(), 0);
  endtask

  initial begin
    int v0;
    rx_if.rxReady = 1'b1;
    repeat (4) @(negedge clock);
    check("reset_valid", {31'd0, rx_if.rxValid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_data", {24'd0, rx_if.rxData}, 32'd0);
    check("reset_errors", {29'd0, framingError, overflowError, parityError}, 32'd0);
    resetn = 1'b1;
    idle(2 * Cpb);

    // Two back-to-back bytes, each visible for exactly one cycle.
    v0 = valid_hi;
    send_frame(8'h55, 1'b1, 1'b0);
    send_frame(8'hA3, 1'b1, 1'b0);
    idle(2 * Cpb);
    check("b2b_valid_cycles", valid_hi - v0, 2);
    check_counts("b2b");

    // Short low glitch: FSM leaves idle, then returns without a byte.
    rx = 1'b0;
    repeat (6) @(negedge clock);
    check("glitch_busy_rise", {31'd0, busy}, 32'd1);
    idle(2 * Cpb);
    check("glitch_busy_fall", {31'd0, busy}, 32'd0);
    check_counts("glitch");

    // Bad stop bit followed by a long break gives a single framing error.
    send_frame(8'h41, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (20 * Cpb) @(negedge clock);
    check("break_busy", {31'd0, busy}, 32'd1);
    idle(3 * Cpb);
    check("break_valid", {31'd0, rx_if.rxValid}, 32'd0);
    check_counts("break");

    // Stalled consumer: four bytes fit, the fifth overflows.
    rx_if.rxReady = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
    idle(2 * Cpb);
    check("ovf_pulses", ov_seen, ov_exp);
    check("ovf_head", {24'd0, rx_if.rxData}, 32'h01);
    check("ovf_valid", {31'd0, rx_if.rxValid}, 32'd1);
    rx_if.rxReady = 1'b1;
    idle(Cpb);
    check("drain_valid", {31'd0, rx_if.rxValid}, 32'd0);
    check("drain_last_data", {24'd0, rx_if.rxData}, 32'h04);
    check_counts("ovf");

    // Reset during data bit 3; the sender abandons the frame as well.
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'(8'h7E >> i));
    rx = 1'b1;
    repeat (Cpb / 2) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    idle(2 * Cpb);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_data", {24'd0, rx_if.rxData}, 32'd0);
    send_frame(8'h7E, 1'b1, 1'b0);
    idle(2 * Cpb);
    check_counts("midreset");

`ifdef OCLIB_UART_RX_PARITY_EN
    v0 = valid_hi;
    send_frame(8'h07, 1'b1, 1'b0);
    idle(2 * Cpb);
    check("parity_good_valid_cycles", valid_hi - v0, 1);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(2 * Cpb);
    check("parity_bad_valid_cycles", valid_hi - v0, 1);
    check_counts("parity");
`endif

    // Random traffic with occasional glitches, bad stop bits and parity flips.
    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      logic stop_b, flip;
      d = 8'($urandom);
      stop_b = ($urandom_range(0, 7) != 0);
      flip = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) begin
        rx = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clock);
        idle(2 * Cpb);
      end
      send_frame(d, stop_b, flip);
      if (!stop_b) idle(2 * Cpb);
      else idle($urandom_range(0, 2 * Cpb));
    end
    idle(3 * Cpb);
    check_counts("random");
    check("final_busy", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
